// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding, stage indices and opcode defaults for the hazard controller
package hazard_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STALL   = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_JFLUSH  = 3'd4
  } hz_state_e;

  localparam int IF_ID = 0;
  localparam int ID_EX = 1;
  localparam int EX_M  = 2;
  localparam int M_WB  = 3;

  localparam logic [3:0] OP_LOAD_A = 4'b1100;
  localparam logic [3:0] OP_LOAD_B = 4'b1010;

  function automatic logic [3:0] stage_bit(input int idx);
    return 4'(1) << idx;
  endfunction

  localparam logic [3:0] STG_NONE  = 4'b0000;
  localparam logic [3:0] STG_ALL   = 4'b1111;
  localparam logic [3:0] STG_FRONT = stage_bit(IF_ID) | stage_bit(ID_EX);
  localparam logic [3:0] STG_EXM   = stage_bit(EX_M);

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side bundle between the datapath and the hazard controller
interface hazard_ctrl_if #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  import hazard_pkg::*;

  logic [INSTR_W-1:0] ex_instruction;
  logic [INSTR_W-1:0] m_instruction;
  logic               mem_ready;
  logic               force_flush;
  logic               jump_taken;
  logic               pc_write;
  logic [3:0]         stage_lock;
  logic [3:0]         stage_flush;
  hz_state_e          state;
  logic [CNT_W-1:0]   stall_count;

  modport master (
    output ex_instruction, m_instruction, mem_ready, force_flush, jump_taken,
    input  pc_write, stage_lock, stage_flush, state, stall_count
  );

  modport slave (
    input  ex_instruction, m_instruction, mem_ready, force_flush, jump_taken,
    output pc_write, stage_lock, stage_flush, state, stall_count
  );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - decodes EX/M register fields and flags a load in M and a load-use hazard
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int         INSTR_W    = 16,
  parameter int         REG_W      = 4,
  parameter logic [3:0] LOAD_OP_A  = OP_LOAD_A,
  parameter logic [3:0] LOAD_OP_B  = OP_LOAD_B,
  parameter int         R0_IS_ZERO = 0
) (
  input  logic [INSTR_W-1:0] ex_instruction,
  input  logic [INSTR_W-1:0] m_instruction,
  output logic               load_m,
  output logic               hz
);

  localparam int RD_HI = INSTR_W - 5;
  localparam int RS_HI = RD_HI - REG_W;
  localparam int LOW_W = INSTR_W - 4 - 2 * REG_W;

  logic [3:0]       m_op;
  logic [REG_W-1:0] m_rd;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] ex_rs;
  logic             unused_fields;

  assign m_op  = m_instruction[INSTR_W-1 -: 4];
  assign m_rd  = m_instruction[RD_HI -: REG_W];
  assign ex_rd = ex_instruction[RD_HI -: REG_W];
  assign ex_rs = ex_instruction[RS_HI -: REG_W];

  assign unused_fields = ^{m_instruction[RS_HI -: REG_W], m_instruction[LOW_W-1:0],
                           ex_instruction[INSTR_W-1 -: 4], ex_instruction[LOW_W-1:0]};

  assign load_m = (m_op == LOAD_OP_A) || (m_op == LOAD_OP_B);
  assign hz     = load_m && ((m_rd == ex_rd) || (m_rd == ex_rs))
                  && !((R0_IS_ZERO != 0) && (m_rd == '0));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard FSM: load-use stalls, memory freeze, jump flush, stall statistics
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int         INSTR_W           = 16,
  parameter int         REG_W             = 4,
  parameter logic [3:0] LOAD_OP_A         = OP_LOAD_A,
  parameter logic [3:0] LOAD_OP_B         = OP_LOAD_B,
  parameter int         LOAD_STALL_CYCLES = 1,
  parameter int         JUMP_FLUSH_CYCLES = 1,
  parameter int         R0_IS_ZERO        = 0,
  parameter int         CNT_W             = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int SW = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
  localparam int JW = (JUMP_FLUSH_CYCLES > 1) ? $clog2(JUMP_FLUSH_CYCLES) : 1;

  hz_state_e        state_q, state_d, run_state;
  logic [SW-1:0]    cnt_q, cnt_d, run_cnt;
  logic [JW-1:0]    jcnt_q, jcnt_d, run_jcnt;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             load_m, hz;
  logic             pc_write, run_pc;
  logic [3:0]       lock, flush, run_lock, run_flush;

  hazard_detect #(
    .INSTR_W   (INSTR_W),
    .REG_W     (REG_W),
    .LOAD_OP_A (LOAD_OP_A),
    .LOAD_OP_B (LOAD_OP_B),
    .R0_IS_ZERO(R0_IS_ZERO)
  ) u_detect (
    .ex_instruction(bus.ex_instruction),
    .m_instruction (bus.m_instruction),
    .load_m        (load_m),
    .hz            (hz)
  );

  // RUN decision; MEMWAIT reuses it once memory is ready, so the freeze is gated on RUN
  always_comb begin
    run_state = ST_RUN;
    run_cnt   = cnt_q;
    run_jcnt  = jcnt_q;
    run_pc    = 1'b1;
    run_lock  = STG_NONE;
    run_flush = STG_NONE;
    if (bus.force_flush) begin
      run_lock  = STG_FRONT;
      run_flush = STG_EXM;
    end else if (load_m && !bus.mem_ready && (state_q == ST_RUN)) begin
      run_pc    = 1'b0;
      run_lock  = STG_ALL;
      run_state = ST_MEMWAIT;
    end else if (hz) begin
      run_pc    = 1'b0;
      run_lock  = STG_FRONT;
      run_flush = STG_EXM;
      run_cnt   = SW'(LOAD_STALL_CYCLES - 1);
      run_state = (LOAD_STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
    end else if (bus.jump_taken) begin
      run_flush = STG_FRONT;
      run_jcnt  = JW'(JUMP_FLUSH_CYCLES - 1);
      run_state = (JUMP_FLUSH_CYCLES > 1) ? ST_JFLUSH : ST_RUN;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    jcnt_d   = jcnt_q;
    pc_write = 1'b1;
    lock     = STG_NONE;
    flush    = STG_NONE;
    case (state_q)
      ST_INIT: begin
        pc_write = 1'b0;
        flush    = STG_ALL;
        state_d  = ST_RUN;
      end
      ST_STALL: begin
        lock  = STG_FRONT;
        flush = STG_EXM;
        if (bus.force_flush) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          pc_write = 1'b0;
          if (cnt_q <= SW'(1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - SW'(1);
          end
        end
      end
      ST_JFLUSH: begin
        if (bus.force_flush) begin
          lock    = STG_FRONT;
          flush   = STG_EXM;
          jcnt_d  = '0;
          state_d = ST_RUN;
        end else begin
          flush = STG_FRONT;
          if (bus.jump_taken) begin
            jcnt_d = JW'(JUMP_FLUSH_CYCLES - 1);
          end else if (jcnt_q <= JW'(1)) begin
            jcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            jcnt_d = jcnt_q - JW'(1);
          end
        end
      end
      ST_MEMWAIT: begin
        if (!bus.force_flush && !bus.mem_ready) begin
          pc_write = 1'b0;
          lock     = STG_ALL;
        end else begin
          pc_write = run_pc;
          lock     = run_lock;
          flush    = run_flush;
          state_d  = run_state;
          cnt_d    = run_cnt;
          jcnt_d   = run_jcnt;
        end
      end
      ST_RUN: begin
        pc_write = run_pc;
        lock     = run_lock;
        flush    = run_flush;
        state_d  = run_state;
        cnt_d    = run_cnt;
        jcnt_d   = run_jcnt;
      end
      default: state_d = ST_INIT;
    endcase
    if (!reset) begin
      pc_write = 1'b0;
      lock     = STG_ALL;
      flush    = STG_ALL;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write && (state_q inside {ST_RUN, ST_STALL, ST_MEMWAIT}) && (stall_count_q != '1))
      stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      jcnt_q        <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      jcnt_q        <= jcnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.stage_lock  = lock;
  assign bus.stage_flush = flush;
  assign bus.state       = state_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - two differently parameterised hazard controllers against a cycle-count reference model
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] ex_i, m_i;
  logic        rdy, ff, jmp;

  hazard_ctrl_if #(.INSTR_W(16), .CNT_W(16)) bus_a ();
  hazard_ctrl_if #(.INSTR_W(16), .CNT_W(4))  bus_b ();

  assign bus_a.ex_instruction = ex_i;
  assign bus_a.m_instruction  = m_i;
  assign bus_a.mem_ready      = rdy;
  assign bus_a.force_flush    = ff;
  assign bus_a.jump_taken     = jmp;
  assign bus_b.ex_instruction = ex_i;
  assign bus_b.m_instruction  = m_i;
  assign bus_b.mem_ready      = rdy;
  assign bus_b.force_flush    = ff;
  assign bus_b.jump_taken     = jmp;

  hazard_ctrl #(
    .INSTR_W(16), .REG_W(4), .LOAD_OP_A(4'b1100), .LOAD_OP_B(4'b1010),
    .LOAD_STALL_CYCLES(3), .JUMP_FLUSH_CYCLES(2), .R0_IS_ZERO(1), .CNT_W(16)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  hazard_ctrl #(
    .INSTR_W(16), .REG_W(4), .LOAD_OP_A(4'b1100), .LOAD_OP_B(4'b1010),
    .LOAD_STALL_CYCLES(1), .JUMP_FLUSH_CYCLES(1), .R0_IS_ZERO(0), .CNT_W(4)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Pipeline condition as "cycles still owed" rather than FSM states
  typedef struct {
    bit init;
    int stall_left;
    bit mem_wait;
    int flush_left;
    int cnt;
  } mdl_t;

  mdl_t mdl [2];
  mdl_t nxt [2];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic       obs_pc    [2];
  logic [3:0] obs_lock  [2];
  logic [3:0] obs_flush [2];
  logic [2:0] obs_state [2];
  int         obs_cnt   [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic void model_step(input int k, input mdl_t cur, output mdl_t nx,
                                     output bit pc, output logic [3:0] lk, output logic [3:0] fl,
                                     output int st, output int cnt_exp);
    int lsc, jfc, cmax;
    bit r0z, is_load, hazard;
    logic [3:0] mop, mrd, erd, ers;
    lsc  = (k == 0) ? 3 : 1;
    jfc  = (k == 0) ? 2 : 1;
    r0z  = (k == 0);
    cmax = (k == 0) ? 65535 : 15;
    mop = m_i[15:12];
    mrd = m_i[11:8];
    erd = ex_i[11:8];
    ers = ex_i[7:4];
    is_load = (mop == 4'hC) || (mop == 4'hA);
    hazard  = is_load && ((mrd == erd) || (mrd == ers)) && !(r0z && (mrd == 4'd0));
    nx = cur;
    pc = 1'b1;
    lk = 4'h0;
    fl = 4'h0;
    if (!reset) begin
      pc = 1'b0; lk = 4'hF; fl = 4'hF; st = 0; cnt_exp = 0;
      nx = '{init: 1'b1, stall_left: 0, mem_wait: 1'b0, flush_left: 0, cnt: 0};
      return;
    end
    cnt_exp = cur.cnt;
    if (cur.init) st = 0;
    else if (cur.stall_left > 0) st = 2;
    else if (cur.mem_wait) st = 3;
    else if (cur.flush_left > 0) st = 4;
    else st = 1;
    if (cur.init) begin
      pc = 1'b0; fl = 4'hF; nx.init = 1'b0;
    end else if (ff) begin
      lk = 4'h3; fl = 4'h4;
      nx.stall_left = 0; nx.flush_left = 0; nx.mem_wait = 1'b0;
    end else if (cur.stall_left > 0) begin
      pc = 1'b0; lk = 4'h3; fl = 4'h4;
      nx.stall_left = cur.stall_left - 1;
    end else if (cur.flush_left > 0) begin
      fl = 4'h3;
      nx.flush_left = jmp ? jfc - 1 : cur.flush_left - 1;
    end else if (cur.mem_wait && !rdy) begin
      pc = 1'b0; lk = 4'hF;
    end else if (!cur.mem_wait && is_load && !rdy) begin
      pc = 1'b0; lk = 4'hF; nx.mem_wait = 1'b1;
    end else begin
      nx.mem_wait = 1'b0;
      if (hazard) begin
        pc = 1'b0; lk = 4'h3; fl = 4'h4; nx.stall_left = lsc - 1;
      end else if (jmp) begin
        fl = 4'h3; nx.flush_left = jfc - 1;
      end
    end
    if (!pc && !cur.init && cur.cnt < cmax) nx.cnt = cur.cnt + 1;
  endfunction

  task automatic step_cycle(input string tag);
    bit pc;
    logic [3:0] lk, fl;
    int st, ce;
    string nm;
    @(negedge clk);
    obs_pc[0] = bus_a.pc_write;  obs_lock[0] = bus_a.stage_lock;  obs_flush[0] = bus_a.stage_flush;
    obs_state[0] = bus_a.state;  obs_cnt[0] = int'(bus_a.stall_count);
    obs_pc[1] = bus_b.pc_write;  obs_lock[1] = bus_b.stage_lock;  obs_flush[1] = bus_b.stage_flush;
    obs_state[1] = bus_b.state;  obs_cnt[1] = int'(bus_b.stall_count);
    for (int k = 0; k < 2; k++) begin
      model_step(k, mdl[k], nxt[k], pc, lk, fl, st, ce);
      nm = $sformatf("%s_%s", tag, (k == 0) ? "a" : "b");
      check_eq({nm, "_pc"},    32'(obs_pc[k]),    32'(pc));
      check_eq({nm, "_lock"},  32'(obs_lock[k]),  32'(lk));
      check_eq({nm, "_flush"}, 32'(obs_flush[k]), 32'(fl));
      check_eq({nm, "_state"}, 32'(obs_state[k]), 32'(st));
      check_eq({nm, "_cnt"},   32'(obs_cnt[k]),   32'(ce));
    end
    @(posedge clk);
    mdl[0] = nxt[0];
    mdl[1] = nxt[1];
    #1;
  endtask

  task automatic idle();
    m_i = 16'h0000; ex_i = 16'h0000; rdy = 1'b1; ff = 1'b0; jmp = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    mdl[0] = '{init: 1'b1, stall_left: 0, mem_wait: 1'b0, flush_left: 0, cnt: 0};
    mdl[1] = mdl[0];
    #1;
    repeat (3) step_cycle("rst");
    check_eq("rst_lock_a", 32'(obs_lock[0]), 32'hF);
    reset = 1'b1;
    step_cycle("init");
    check_eq("init_flush_a", 32'(obs_flush[0]), 32'hF);
    check_eq("init_pc_b", 32'(obs_pc[1]), 32'h0);
    step_cycle("run");
    check_eq("run_pc_a", 32'(obs_pc[0]), 32'h1);

    m_i = 16'hC300; ex_i = 16'h0530;
    step_cycle("lu");
    idle();
    repeat (3) step_cycle("lu");
    check_eq("lu_cnt_a", 32'(obs_cnt[0]), 32'd3);
    check_eq("lu_cnt_b", 32'(obs_cnt[1]), 32'd1);

    m_i = 16'hA000; ex_i = 16'h0000;
    step_cycle("r0");
    check_eq("r0_pc_a", 32'(obs_pc[0]), 32'h1);
    check_eq("r0_pc_b", 32'(obs_pc[1]), 32'h0);
    idle();
    step_cycle("r0");

    m_i = 16'hC300; rdy = 1'b0;
    repeat (4) step_cycle("mw");
    check_eq("mw_lock_a", 32'(obs_lock[0]), 32'hF);
    rdy = 1'b1;
    step_cycle("mw");
    check_eq("mw_rel_lock_a", 32'(obs_lock[0]), 32'h0);
    check_eq("mw_cnt_a", 32'(obs_cnt[0]), 32'd7);
    check_eq("mw_cnt_b", 32'(obs_cnt[1]), 32'd6);
    idle();

    jmp = 1'b1; step_cycle("j1");
    jmp = 1'b0; step_cycle("j1");
    check_eq("j1_flush_a", 32'(obs_flush[0]), 32'h3);
    check_eq("j1_flush_b", 32'(obs_flush[1]), 32'h0);
    step_cycle("j1");
    jmp = 1'b1; step_cycle("j2");
    step_cycle("j2");
    jmp = 1'b0; step_cycle("j2");
    check_eq("j2_flush_a", 32'(obs_flush[0]), 32'h3);
    check_eq("j2_pc_a", 32'(obs_pc[0]), 32'h1);
    step_cycle("j2");

    m_i = 16'hC300; ex_i = 16'h0530; step_cycle("ffs");
    idle(); ff = 1'b1; step_cycle("ffs");
    check_eq("ffs_lock_a", 32'(obs_lock[0]), 32'h3);
    check_eq("ffs_pc_a", 32'(obs_pc[0]), 32'h1);
    ff = 1'b0; step_cycle("ffs");
    check_eq("ffs_state_a", 32'(obs_state[0]), 32'd1);

    m_i = 16'hC300; rdy = 1'b0; step_cycle("ffm");
    ff = 1'b1; step_cycle("ffm");
    check_eq("ffm_flush_a", 32'(obs_flush[0]), 32'h4);
    idle(); step_cycle("ffm");
    check_eq("ffm_state_a", 32'(obs_state[0]), 32'd1);

    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 3))
        0:       m_i[15:12] = 4'hC;
        1:       m_i[15:12] = 4'hA;
        default: m_i[15:12] = 4'($urandom);
      endcase
      m_i[11:0] = {4'($urandom_range(0, 3)), 8'($urandom)};
      ex_i = {4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
      rdy   = ($urandom_range(0, 9) < 6);
      jmp   = ($urandom_range(0, 9) < 2);
      ff    = ($urandom_range(0, 19) == 0);
      reset = !($urandom_range(0, 99) == 0);
      step_cycle("rnd");
    end

    idle(); reset = 1'b1;
    repeat (2) step_cycle("pre");
    m_i = 16'hC300; ex_i = 16'h0530; step_cycle("rms");
    idle(); reset = 1'b0; step_cycle("rms");
    check_eq("rms_flush_a", 32'(obs_flush[0]), 32'hF);
    check_eq("rms_cnt_a", 32'(obs_cnt[0]), 32'd0);
    reset = 1'b1; step_cycle("rms");
    check_eq("rms_init_a", 32'(obs_state[0]), 32'd0);
    step_cycle("rms");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
